// File: rtl/open_loop_flow_sched.sv
// ============================================================================
//  Module   : open_loop_flow_sched
//  Purpose  : Per-flow round-robin request scheduler for the open-loop TCP app.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module open_loop_flow_sched #(
  parameter int FLOWID_W      = 7,
  parameter int PAYLOAD_PTR_W = 14
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     setup_val,
  input  logic [FLOWID_W-1:0]      setup_flowid,
  input  logic [31:0]              setup_total_reqs,
  input  logic [31:0]              setup_bufsize,
  input  logic                     setup_should_copy,
  output logic                     setup_rdy,
  output logic                     req_val,
  output logic [FLOWID_W-1:0]      req_flowid,
  output logic [PAYLOAD_PTR_W:0]   req_len,
  output logic                     req_copy,
  input  logic                     req_rdy,
  output logic                     done_val,
  output logic [FLOWID_W-1:0]      done_flowid,
  input  logic                     done_rdy,
  output logic [FLOWID_W:0]        active_cnt
);

  localparam int          NUM_FLOWS = 2 ** FLOWID_W;
  localparam logic [31:0] MAX_LEN   = 32'(2 ** PAYLOAD_PTR_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PICK  = 2'd1,
    ISSUE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t r_state, w_state_nxt;

  logic [31:0]            r_total   [NUM_FLOWS];
  logic [31:0]            r_bufsize [NUM_FLOWS];
  logic [31:0]            r_curr    [NUM_FLOWS];
  logic [NUM_FLOWS-1:0]   r_copy;
  logic [NUM_FLOWS-1:0]   r_active;
  logic [FLOWID_W-1:0]    r_rr_ptr;
  logic [FLOWID_W-1:0]    r_sel;
  logic [PAYLOAD_PTR_W:0] r_req_len;
  logic                   r_req_copy;
  logic [FLOWID_W:0]      r_active_cnt;

  logic                   w_setup_hs;
  logic                   w_setup_empty;
  logic                   w_req_hs;
  logic                   w_last_req;
  logic [31:0]            w_new_curr;
  logic [FLOWID_W-1:0]    w_pick_idx;
  logic [PAYLOAD_PTR_W:0] w_pick_len;
  logic [FLOWID_W:0]      w_popcount;

  assign w_setup_hs    = setup_val && setup_rdy;
  assign w_setup_empty = (setup_total_reqs == 32'd0) || (setup_bufsize == 32'd0);
  assign w_req_hs      = (r_state == ISSUE) && req_rdy;
  assign w_new_curr    = r_curr[r_sel] + 32'd1;
  assign w_last_req    = (w_new_curr == r_total[r_sel]);

  // Walk offsets from farthest to nearest so the nearest active flow after
  // rr_ptr wins; offset NUM_FLOWS wraps to rr_ptr itself as the last resort.
  always_comb begin
    w_pick_idx = r_rr_ptr;
    for (int i = NUM_FLOWS; i >= 1; i--) begin
      if (r_active[r_rr_ptr + FLOWID_W'(i)]) begin
        w_pick_idx = r_rr_ptr + FLOWID_W'(i);
      end
    end
  end

  assign w_pick_len = (r_bufsize[w_pick_idx] > MAX_LEN) ? MAX_LEN[PAYLOAD_PTR_W:0]
                                                        : r_bufsize[w_pick_idx][PAYLOAD_PTR_W:0];

  always_comb begin
    w_popcount = '0;
    for (int i = 0; i < NUM_FLOWS; i++) begin
      w_popcount = w_popcount + (FLOWID_W+1)'(r_active[i]);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_setup_hs) begin
          w_state_nxt = w_setup_empty ? DONE : IDLE;
        end else if (|r_active) begin
          w_state_nxt = PICK;
        end
      end
      PICK:  w_state_nxt = ISSUE;
      ISSUE: begin
        if (req_rdy) begin
          w_state_nxt = w_last_req ? DONE : IDLE;
        end
      end
      DONE: begin
        if (done_rdy) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_active     <= '0;
      r_rr_ptr     <= FLOWID_W'(NUM_FLOWS - 1);
      r_sel        <= '0;
      r_req_len    <= '0;
      r_req_copy   <= 1'b0;
      r_active_cnt <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_active_cnt <= w_popcount;
      if (w_setup_hs) begin
        r_active[setup_flowid] <= !w_setup_empty;
        if (w_setup_empty) begin
          r_sel <= setup_flowid;
        end
      end
      if (r_state == PICK) begin
        r_sel      <= w_pick_idx;
        r_req_len  <= w_pick_len;
        r_req_copy <= r_copy[w_pick_idx];
      end
      if (w_req_hs) begin
        r_rr_ptr <= r_sel;
        if (w_last_req) begin
          r_active[r_sel] <= 1'b0;
        end
      end
    end
  end

  // Context storage carries no reset: a flow is only read after its setup.
  always_ff @(posedge clk) begin
    if (w_setup_hs) begin
      r_total[setup_flowid]   <= setup_total_reqs;
      r_bufsize[setup_flowid] <= setup_bufsize;
      r_copy[setup_flowid]    <= setup_should_copy;
      r_curr[setup_flowid]    <= 32'd0;
    end else if (w_req_hs) begin
      r_curr[r_sel] <= w_new_curr;
    end
  end

  assign setup_rdy   = (r_state == IDLE) && rst_n;
  assign req_val     = (r_state == ISSUE);
  assign req_flowid  = r_sel;
  assign req_len     = r_req_len;
  assign req_copy    = r_req_copy;
  assign done_val    = (r_state == DONE);
  assign done_flowid = r_sel;
  assign active_cnt  = r_active_cnt;

endmodule

`default_nettype wire
